// File: rtl/issue_queue_age_pkg.sv
// Shared types for the parametrised integer issue queue: micro-op layout,
// functional-unit code, operand source encoding and wakeup helper.
package issue_queue_age_pkg;

    localparam int unsigned FU_TYPES  = 4;
    localparam int unsigned PRF_IDX_W = 6;

    // Bit order {div, mul, br, alu}; alu is bit 0 to line up with PORT_FU_MASK.
    typedef struct packed {
        logic div;
        logic mul;
        logic br;
        logic alu;
    } fu_code_t;

    typedef enum logic [1:0] {
        RS_FROM_RF   = 2'd0,
        RS_FROM_IMM  = 2'd1,
        RS_FROM_PC   = 2'd2,
        RS_FROM_ZERO = 2'd3
    } rs_source_t;

    typedef struct packed {
        logic                 valid;
        logic [7:0]           id;
        fu_code_t             fu_code;
        rs_source_t           rs1_source;
        logic                 rs1_from_ctb;
        logic [PRF_IDX_W-1:0] rs1_prf_index;
        rs_source_t           rs2_source;
        logic                 rs2_from_ctb;
        logic [PRF_IDX_W-1:0] rs2_prf_index;
        logic [PRF_IDX_W-1:0] rd_prf_index;
    } micro_op_t;

    localparam int unsigned UOP_W = $bits(micro_op_t);

    // An operand only waits for the tag bus when it is read from the PRF and
    // its producer has not yet broadcast.
    function automatic logic needs_wakeup(rs_source_t src, logic from_ctb);
        return (src == RS_FROM_RF) && from_ctb;
    endfunction

endpackage

// File: rtl/issue_queue_age_iq_slot.sv
// One issue-queue slot: holds a micro-op and its operand ready bits, and
// watches the common tag bus to wake waiting operands.
module issue_queue_age_iq_slot
    import issue_queue_age_pkg::*;
#(
    parameter int unsigned CTB_WIDTH      = 3,
    parameter int unsigned PRF_INDEX_SIZE = PRF_IDX_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic                                load_i,
    input  logic                                issue_i,
    input  logic [UOP_W-1:0]                    uop_i,
    input  logic [CTB_WIDTH*PRF_INDEX_SIZE-1:0] ctb_prf_index_i,
    input  logic [CTB_WIDTH-1:0]                ctb_valid_i,
    output logic                                valid_o,
    output logic                                ready_o,
    output logic [UOP_W-1:0]                    uop_o
);

    micro_op_t uop_in;
    micro_op_t uop_q, uop_d;
    logic      valid_q, valid_d;
    logic      rs1_ready_q, rs1_ready_d;
    logic      rs2_ready_q, rs2_ready_d;
    logic      rs1_hit_in, rs2_hit_in, rs1_hit_q, rs2_hit_q;

    assign uop_in = uop_i;

    // Compare both incoming and stored source tags against every CTB lane.
    always_comb begin
        rs1_hit_in = 1'b0;
        rs2_hit_in = 1'b0;
        rs1_hit_q  = 1'b0;
        rs2_hit_q  = 1'b0;
        for (int c = 0; c < CTB_WIDTH; c++) begin
            if (ctb_valid_i[c]) begin
                if (ctb_prf_index_i[c*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] == uop_in.rs1_prf_index)
                    rs1_hit_in = 1'b1;
                if (ctb_prf_index_i[c*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] == uop_in.rs2_prf_index)
                    rs2_hit_in = 1'b1;
                if (ctb_prf_index_i[c*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] == uop_q.rs1_prf_index)
                    rs1_hit_q = 1'b1;
                if (ctb_prf_index_i[c*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] == uop_q.rs2_prf_index)
                    rs2_hit_q = 1'b1;
            end
        end
    end

    // Next state: load wins over wakeup; ready bits are sticky until reload.
    always_comb begin
        valid_d     = valid_q;
        uop_d       = uop_q;
        rs1_ready_d = rs1_ready_q | rs1_hit_q;
        rs2_ready_d = rs2_ready_q | rs2_hit_q;
        if (load_i) begin
            valid_d     = 1'b1;
            uop_d       = uop_in;
            rs1_ready_d = ~needs_wakeup(uop_in.rs1_source, uop_in.rs1_from_ctb) | rs1_hit_in;
            rs2_ready_d = ~needs_wakeup(uop_in.rs2_source, uop_in.rs2_from_ctb) | rs2_hit_in;
        end else if (issue_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; flush behaves like reset.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            valid_q     <= 1'b0;
            uop_q       <= '0;
            rs1_ready_q <= 1'b0;
            rs2_ready_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            uop_q       <= uop_d;
            rs1_ready_q <= rs1_ready_d;
            rs2_ready_q <= rs2_ready_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = valid_q & rs1_ready_q & rs2_ready_q;
    assign uop_o   = uop_q;

endmodule

// File: rtl/issue_queue_age.sv
// Parametrised integer issue queue: packs dispatched uops into free slots,
// selects up to one ready uop per execution port and tracks free slots.
// Define IQ_AGE_ORDER_EN for oldest-first selection via a DEPTH x DEPTH age
// matrix; otherwise each port takes the lowest-index eligible slot.
module issue_queue_age
    import issue_queue_age_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH    = 3,
    parameter int unsigned CTB_WIDTH      = 3,
    parameter int unsigned PRF_INDEX_SIZE = PRF_IDX_W,
    // Port p at [4p+3:4p], bits {div,mul,br,alu}: p0 alu|br, p1 alu|mul, p2 alu|div.
    parameter logic [ISSUE_WIDTH*FU_TYPES-1:0] PORT_FU_MASK = 12'b1001_0101_0011,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic [CTB_WIDTH*PRF_INDEX_SIZE-1:0] ctb_prf_index_i,
    input  logic [CTB_WIDTH-1:0]                ctb_valid_i,
    input  logic [ISSUE_WIDTH-1:0]              ex_busy_i,
    input  logic [DISPATCH_WIDTH*UOP_W-1:0]     uop_in_i,
    output logic [ISSUE_WIDTH*UOP_W-1:0]        uop_out_o,
    output logic [CNT_W-1:0]                    free_count_o,
    output logic                                iq_full_o
);

    logic [DEPTH-1:0] slot_valid, slot_ready, load_en, issue_en;
    micro_op_t        slot_uop [DEPTH];
    micro_op_t        load_uop [DEPTH];
    logic [CNT_W-1:0] load_cnt, issue_cnt;
    logic [CNT_W-1:0] free_count_q;
    logic             iq_full_q;
`ifdef IQ_AGE_ORDER_EN
    // older_mask[i] is the row written when slot i loads; age_q[i][j] = j older than i.
    logic [DEPTH-1:0] older_mask [DEPTH];
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
`endif

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        issue_queue_age_iq_slot #(
            .CTB_WIDTH      (CTB_WIDTH),
            .PRF_INDEX_SIZE (PRF_INDEX_SIZE)
        ) u_slot (
            .clock           (clock),
            .reset           (reset),
            .flush_i         (flush_i),
            .load_i          (load_en[s]),
            .issue_i         (issue_en[s]),
            .uop_i           (load_uop[s]),
            .ctb_prf_index_i (ctb_prf_index_i),
            .ctb_valid_i     (ctb_valid_i),
            .valid_o         (slot_valid[s]),
            .ready_o         (slot_ready[s]),
            .uop_o           (slot_uop[s])
        );
    end

    // Pack valid lanes, in lane order, into the lowest free slots.
    always_comb begin
        logic [DEPTH-1:0] avail;
        logic             found;
        micro_op_t        lane_uop;
        avail    = ~slot_valid;
        load_en  = '0;
        load_cnt = '0;
        found    = 1'b0;
        lane_uop = '0;
        for (int s = 0; s < DEPTH; s++) begin
            load_uop[s] = '0;
`ifdef IQ_AGE_ORDER_EN
            older_mask[s] = '0;
`endif
        end
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            lane_uop = uop_in_i[l*UOP_W +: UOP_W];
            found    = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (lane_uop.valid && avail[s] && !found) begin
                    found       = 1'b1;
                    load_uop[s] = lane_uop;
`ifdef IQ_AGE_ORDER_EN
                    older_mask[s] = slot_valid | load_en;
`endif
                    load_en[s]  = 1'b1;
                    avail[s]    = 1'b0;
                    load_cnt    = load_cnt + 1'b1;
                end
            end
        end
    end

    // Resolve ports in order; each takes one eligible slot not already taken.
    always_comb begin
        logic [DEPTH-1:0] elig;
        logic             found;
        micro_op_t        out_uop;
        issue_en  = '0;
        issue_cnt = '0;
        uop_out_o = '0;
        elig      = '0;
        found     = 1'b0;
        out_uop   = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int s = 0; s < DEPTH; s++) begin
                elig[s] = slot_ready[s] & ~issue_en[s] & ~ex_busy_i[p] &
                          ((slot_uop[s].fu_code & PORT_FU_MASK[p*FU_TYPES +: FU_TYPES]) != '0);
            end
            found   = 1'b0;
            out_uop = '0;
            for (int s = 0; s < DEPTH; s++) begin
`ifdef IQ_AGE_ORDER_EN
                if (elig[s] && ((age_q[s] & elig) == '0) && !found) begin
`else
                if (elig[s] && !found) begin
`endif
                    found         = 1'b1;
                    issue_en[s]   = 1'b1;
                    out_uop       = slot_uop[s];
                    out_uop.valid = 1'b1;
                    issue_cnt     = issue_cnt + 1'b1;
                end
            end
            if (!(reset || flush_i)) begin
                uop_out_o[p*UOP_W +: UOP_W] = out_uop;
            end
        end
    end

`ifdef IQ_AGE_ORDER_EN
    // Age next state: set row on load, then clear columns of slots leaving.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = load_en[i] ? older_mask[i] : age_q[i];
            age_d[i] = age_d[i] & ~issue_en;
        end
    end

    // Age matrix registers.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    // Free-slot counter and full flag, both reflecting post-edge occupancy.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            free_count_q <= CNT_W'(DEPTH);
            iq_full_q    <= 1'b0;
        end else begin
            free_count_q <= free_count_q - load_cnt + issue_cnt;
            iq_full_q    <= (free_count_q - load_cnt + issue_cnt) < CNT_W'(DISPATCH_WIDTH);
        end
    end

    assign free_count_o = free_count_q;
    assign iq_full_o    = iq_full_q;

endmodule

// File: tb/tb_issue_queue_age.sv
// Scoreboard bench for issue_queue_age: stimulus pushes expected
// (port, id, cycle) issues; a negedge monitor pops and compares.
module tb_issue_queue_age;
    import issue_queue_age_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 4;
    localparam int unsigned IW    = 3;
    localparam int unsigned CW    = 3;
    localparam int unsigned PW    = PRF_IDX_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam fu_code_t FU_ALU = 4'b0001;
    localparam fu_code_t FU_MUL = 4'b0100;
    localparam fu_code_t FU_DIV = 4'b1000;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic [CW*PW-1:0]    ctb_idx;
    logic [CW-1:0]       ctb_v;
    logic [IW-1:0]       ex_busy;
    micro_op_t [DW-1:0]  lanes;
    micro_op_t [IW-1:0]  outs;
    logic [CNT_W-1:0]    free_count;
    logic                iq_full;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int t0;

    typedef struct {
        int port;
        int id;
        int cyc;
    } exp_t;
    exp_t expq[$];
    exp_t got;

    issue_queue_age dut (
        .clock           (clock),
        .reset           (reset),
        .flush_i         (flush),
        .ctb_prf_index_i (ctb_idx),
        .ctb_valid_i     (ctb_v),
        .ex_busy_i       (ex_busy),
        .uop_in_i        (lanes),
        .uop_out_o       (outs),
        .free_count_o    (free_count),
        .iq_full_o       (iq_full)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic micro_op_t mk(int id, fu_code_t fu, logic c1, int t1, logic c2, int t2,
                                     rs_source_t s1);
        micro_op_t u;
        u               = '0;
        u.valid         = 1'b1;
        u.id            = 8'(id);
        u.fu_code       = fu;
        u.rs1_source    = s1;
        u.rs1_from_ctb  = c1;
        u.rs1_prf_index = PW'(t1);
        u.rs2_source    = RS_FROM_RF;
        u.rs2_from_ctb  = c2;
        u.rs2_prf_index = PW'(t2);
        u.rd_prf_index  = PW'(id);
        return u;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        lanes = '0;
        ctb_v = '0;
        flush = 1'b0;
    endtask

    task automatic ctb(int lane, int tag);
        ctb_v[lane]            = 1'b1;
        ctb_idx[lane*PW +: PW] = PW'(tag);
    endtask

    task automatic push(int p, int id, int c);
        exp_t e;
        e.port = p;
        e.id   = id;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid port output must match the next expected issue.
    always @(negedge clock) begin
        if (!reset) begin
            for (int p = 0; p < IW; p++) begin
                tests++;
                if (outs[p].valid) begin
                    if (expq.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_issue: port %0d id %0d cycle %0d, none expected",
                                 p, outs[p].id, cyc);
                    end else begin
                        got = expq.pop_front();
                        if (got.port != p || got.id != int'(outs[p].id) || got.cyc != cyc) begin
                            fails++;
                            $display("FAIL issue: got port %0d id %0d cycle %0d, expected port %0d id %0d cycle %0d",
                                     p, outs[p].id, cyc, got.port, got.id, got.cyc);
                        end
                    end
                end else if (outs[p] !== '0) begin
                    fails++;
                    $display("FAIL idle_port_zero: port %0d not all-zero at cycle %0d, expected 0",
                             p, cyc);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        ex_busy = '0;
        ctb_idx = '0;
        idle();
        repeat (3) tick();
        check("reset_uop_out_zero", int'(outs == '0), 1);
        check("reset_free_count", int'(free_count), 16);
        check("reset_iq_full", int'(iq_full), 0);
        reset = 1'b0;

        // Four ready ALU uops: three issue next cycle, the fourth one later.
        t0 = cyc;
        for (int l = 0; l < 4; l++) lanes[l] = mk(l + 1, FU_ALU, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        push(0, 1, t0 + 1);
        push(1, 2, t0 + 1);
        push(2, 3, t0 + 1);
        push(0, 4, t0 + 2);
        tick();
        idle();
        check("t1_free_after_load", int'(free_count), 12);
        tick();
        check("t1_free_after_3_issue", int'(free_count), 15);
        tick();
        check("t1_free_back_to_16", int'(free_count), 16);
        check("t1_iq_full", int'(iq_full), 0);

        // rs1 waits on tag 7; broadcast two cycles later, issue one cycle after.
        t0 = cyc;
        lanes[0] = mk(5, FU_ALU, 1'b1, 7, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        tick();
        ctb(0, 7);
        push(0, 5, t0 + 3);
        tick();
        idle();
        tick();
        tick();

        // Same-cycle CTB at load (rs1 and rs2), plus a non-RF source that ignores from_ctb.
        t0 = cyc;
        lanes[0] = mk(6, FU_ALU, 1'b1, 9, 1'b0, 0, RS_FROM_RF);
        lanes[1] = mk(7, FU_ALU, 1'b1, 30, 1'b0, 0, RS_FROM_IMM);
        lanes[2] = mk(10, FU_ALU, 1'b0, 0, 1'b1, 9, RS_FROM_RF);
        ctb(1, 9);
        push(0, 6, t0 + 1);
        push(1, 7, t0 + 1);
        push(2, 10, t0 + 1);
        tick();
        idle();
        tick();
        tick();

        // Div held by ex_busy[2] for three cycles; mul goes to port 1 at once.
        t0 = cyc;
        ex_busy  = 3'b100;
        lanes[0] = mk(8, FU_DIV, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        lanes[1] = mk(9, FU_MUL, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        push(1, 9, t0 + 1);
        push(2, 8, t0 + 4);
        tick();
        idle();
        tick();
        tick();
        tick();
        ex_busy = '0;
        tick();
        tick();
        check("t4_free_count", int'(free_count), 16);

        // Age ordering on port 0 only: slot 2 old / slot 5 young, then swapped.
        t0 = cyc;
        ex_busy = 3'b110;
        for (int l = 0; l < 4; l++) lanes[l] = mk(20 + l, FU_ALU, 1'b1, 10 + l, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        lanes[0] = mk(24, FU_ALU, 1'b1, 14, 1'b0, 0, RS_FROM_RF);
        lanes[1] = mk(25, FU_ALU, 1'b1, 15, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        ctb(0, 12);
        ctb(1, 15);
        push(0, 22, t0 + 3);
        push(0, 25, t0 + 4);
        tick();
        idle();
        tick();
        tick();
        lanes[0] = mk(26, FU_ALU, 1'b1, 16, 1'b0, 0, RS_FROM_RF);
        lanes[1] = mk(27, FU_ALU, 1'b1, 17, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        ctb(0, 16);
        push(0, 26, t0 + 7);
        tick();
        idle();
        tick();
        lanes[0] = mk(28, FU_ALU, 1'b1, 18, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        ctb(0, 17);
        ctb(1, 18);
`ifdef IQ_AGE_ORDER_EN
        push(0, 27, t0 + 10);
        push(0, 28, t0 + 11);
`else
        push(0, 28, t0 + 10);
        push(0, 27, t0 + 11);
`endif
        tick();
        idle();
        tick();
        tick();
        check("t5_free_count", int'(free_count), 12);

        // Fill to 13 entries, then flush alongside two valid dispatch lanes.
        ex_busy = 3'b100;
        flush   = 1'b1;
        tick();
        idle();
        check("t6_free_after_flush", int'(free_count), 16);
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 4; l++) lanes[l] = mk(40 + 4*k + l, FU_ALU, 1'b1, 40, 1'b0, 0, RS_FROM_RF);
            tick();
        end
        idle();
        check("t6_free_12_used", int'(free_count), 4);
        check("t6_not_full_at_4", int'(iq_full), 0);
        lanes[0] = mk(60, FU_DIV, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        tick();
        idle();
        check("t6_free_13_used", int'(free_count), 3);
        check("t6_full_at_3", int'(iq_full), 1);
        flush    = 1'b1;
        ex_busy  = '0;
        lanes[0] = mk(61, FU_ALU, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        lanes[1] = mk(62, FU_ALU, 1'b0, 0, 1'b0, 0, RS_FROM_RF);
        #1;
        check("t6_flush_uop_out_zero", int'(outs == '0), 1);
        tick();
        idle();
        check("t6_free_after_flush_load", int'(free_count), 16);
        check("t6_not_full_after_flush", int'(iq_full), 0);
        tick();
        tick();

        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
